// File: rtl/mul_sequencer.sv
// Control sequencer for the ARMv4 multiply unit: loads operands, waits out the
// multiplier latency, then steers the low/high product writes and flag update.
module mul_sequencer #(
    parameter int unsigned MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] instr,
    input  logic        hold,
    output logic        busy,
    output logic        done,
    output logic [3:0]  rf_ra,
    output logic [3:0]  rf_rb,
    output logic        rf_oe,
    output logic        LD_MUL,
    output logic        Gate_MUL,
    output logic        MUL_HiLo,
    output logic        U,
    output logic [1:0]  alu_acc,
    output logic        rf_we,
    output logic [3:0]  rf_wa,
    output logic        flag_we,
    output logic        flag_long
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_WAIT  = 3'd2,
        S_WR_LO = 3'd3,
        S_WR_HI = 3'd4
    } state_t;

    localparam int unsigned LAT_M2   = (MUL_LAT >= 2) ? (MUL_LAT - 2) : 0;
    localparam logic [3:0]  CNT_INIT = 4'(LAT_M2);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] instr_q, instr_d;

    logic        is_long_s;
    logic        is_acc_s;
    logic        set_flags_s;
    logic        signed_s;
    logic        instr_unused_s;

    assign is_long_s      = instr_q[23];
    assign is_acc_s       = instr_q[21];
    assign set_flags_s    = instr_q[20];
    assign signed_s       = instr_q[23] & instr_q[22];
    assign instr_unused_s = ^{instr_q[31:24], instr_q[7:4]};

    // State, latency counter and latched instruction; hold freezes all three.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            instr_q <= 32'd0;
        end else if (!hold) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
        end else begin
            state_q <= state_q;
            cnt_q   <= cnt_q;
            instr_q <= instr_q;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        instr_d = instr_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    instr_d = instr;
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                if (MUL_LAT == 1) begin
                    state_d = S_WR_LO;
                end else begin
                    cnt_d   = CNT_INIT;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_WR_LO;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_WR_LO: begin
                if (is_long_s) begin
                    state_d = S_WR_HI;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WR_HI: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from state and latched fields; hold masks only the strobes.
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        rf_ra     = 4'd0;
        rf_rb     = 4'd0;
        rf_oe     = 1'b0;
        LD_MUL    = 1'b0;
        Gate_MUL  = 1'b0;
        MUL_HiLo  = 1'b0;
        U         = 1'b0;
        alu_acc   = 2'b00;
        rf_we     = 1'b0;
        rf_wa     = 4'd0;
        flag_we   = 1'b0;
        flag_long = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
            end
            S_LOAD: begin
                busy   = 1'b1;
                U      = signed_s;
                rf_ra  = instr_q[3:0];
                rf_rb  = instr_q[11:8];
                rf_oe  = 1'b1;
                LD_MUL = ~hold;
            end
            S_WAIT: begin
                busy = 1'b1;
                U    = signed_s;
            end
            S_WR_LO: begin
                busy     = 1'b1;
                U        = signed_s;
                Gate_MUL = 1'b1;
                rf_rb    = instr_q[15:12];
                alu_acc  = is_acc_s ? 2'b01 : 2'b00;
                rf_we    = ~hold;
                if (is_long_s) begin
                    rf_wa = instr_q[15:12];
                end else begin
                    rf_wa   = instr_q[19:16];
                    done    = ~hold;
                    flag_we = set_flags_s & ~hold;
                end
            end
            S_WR_HI: begin
                busy      = 1'b1;
                U         = signed_s;
                Gate_MUL  = 1'b1;
                MUL_HiLo  = 1'b1;
                rf_rb     = instr_q[19:16];
                alu_acc   = is_acc_s ? 2'b10 : 2'b00;
                rf_we     = ~hold;
                rf_wa     = instr_q[19:16];
                done      = ~hold;
                flag_we   = set_flags_s & ~hold;
                flag_long = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mul_sequencer.sv
// Bench for mul_sequencer: three latencies driven in parallel and compared every
// cycle against a step-counting model of the multiply sequence.
module tb_mul_sequencer;

    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, hold;
    logic [31:0] instr;

    logic       busy [NI], done [NI], rf_oe [NI], LD_MUL [NI], Gate_MUL [NI];
    logic       MUL_HiLo [NI], U [NI], rf_we [NI], flag_we [NI], flag_long [NI];
    logic [3:0] rf_ra [NI], rf_rb [NI], rf_wa [NI];
    logic [1:0] alu_acc [NI];

    genvar g;
    generate
        for (g = 0; g < NI; g++) begin : g_dut
            localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 2 : 5);
            mul_sequencer #(.MUL_LAT(LAT)) u_dut (
                .clk(clk), .reset(reset), .start(start), .instr(instr), .hold(hold),
                .busy(busy[g]), .done(done[g]), .rf_ra(rf_ra[g]), .rf_rb(rf_rb[g]),
                .rf_oe(rf_oe[g]), .LD_MUL(LD_MUL[g]), .Gate_MUL(Gate_MUL[g]),
                .MUL_HiLo(MUL_HiLo[g]), .U(U[g]), .alu_acc(alu_acc[g]),
                .rf_we(rf_we[g]), .rf_wa(rf_wa[g]), .flag_we(flag_we[g]),
                .flag_long(flag_long[g])
            );
        end
    endgenerate

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    // Model: an operation is a numbered sequence of cycles 1..len, advanced only when not held.
    int          m_lat [NI] = '{1, 2, 5};
    bit          m_act [NI];
    int          m_k   [NI];
    logic [31:0] m_ins [NI];

    task automatic check_eq(input string tag, input logic [23:0] got, input logic [23:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] exp_out(input bit act, input int k, input logic [31:0] ins,
                                            input int lat, input bit h);
        logic       bz, dn, oe, ld, gt, hl, uu, we, fw, fl;
        logic [3:0] ra, rb, wa;
        logic [1:0] alu;
        {bz, dn, oe, ld, gt, hl, uu, we, fw, fl} = 10'd0;
        ra = 4'd0; rb = 4'd0; wa = 4'd0; alu = 2'b00;
        if (act) begin
            bz = 1'b1;
            uu = ins[23] & ins[22];
            if (k == 1) begin
                ra = ins[3:0]; rb = ins[11:8]; oe = 1'b1; ld = !h;
            end else if (k == lat + 1) begin
                gt = 1'b1; rb = ins[15:12]; alu = ins[21] ? 2'b01 : 2'b00; we = !h;
                if (ins[23]) begin
                    wa = ins[15:12];
                end else begin
                    wa = ins[19:16]; dn = !h; fw = ins[20] & !h;
                end
            end else if (k == lat + 2) begin
                gt = 1'b1; hl = 1'b1; rb = ins[19:16]; alu = ins[21] ? 2'b10 : 2'b00;
                we = !h; wa = ins[19:16]; dn = !h; fw = ins[20] & !h; fl = 1'b1;
            end
        end
        return {bz, dn, ra, rb, oe, ld, gt, hl, uu, alu, we, wa, fw, fl};
    endfunction

    task automatic step(input bit r, input bit s, input logic [31:0] ins, input bit h);
        logic [23:0] obs;
        @(negedge clk);
        reset = r; start = s; instr = ins; hold = h;
        if (r) begin
            for (int i = 0; i < NI; i++) m_act[i] = 1'b0;
        end
        #1;
        for (int i = 0; i < NI; i++) begin
            obs = {busy[i], done[i], rf_ra[i], rf_rb[i], rf_oe[i], LD_MUL[i], Gate_MUL[i],
                   MUL_HiLo[i], U[i], alu_acc[i], rf_we[i], rf_wa[i], flag_we[i], flag_long[i]};
            check_eq($sformatf("lat%0d_cyc%0d", m_lat[i], cyc), obs,
                     exp_out(m_act[i], m_k[i], m_ins[i], m_lat[i], h));
        end
        cyc++;
        @(posedge clk);
        for (int i = 0; i < NI; i++) begin
            if (!reset && !hold) begin
                if (!m_act[i]) begin
                    if (start) begin
                        m_act[i] = 1'b1; m_k[i] = 1; m_ins[i] = instr;
                    end
                end else if (m_k[i] == m_lat[i] + 1 + (m_ins[i][23] ? 1 : 0)) begin
                    m_act[i] = 1'b0;
                end else begin
                    m_k[i]++;
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; hold = 1'b0; instr = 32'd0;
        for (int i = 0; i < NI; i++) begin
            m_act[i] = 1'b0; m_k[i] = 0; m_ins[i] = 32'd0;
        end
        repeat (2) step(1'b1, 1'b0, 32'd0, 1'b0);
        // Back-to-back MUL with start held high.
        repeat (14) step(1'b0, 1'b1, 32'h0002_0190, 1'b0);
        repeat (8) step(1'b0, 1'b0, 32'd0, 1'b0);
        // UMLAL and SMULLS, single start pulses.
        step(1'b0, 1'b1, 32'h00A4_3291, 1'b0);
        repeat (9) step(1'b0, 1'b0, 32'd0, 1'b0);
        step(1'b0, 1'b1, 32'h00D4_3291, 1'b0);
        repeat (9) step(1'b0, 1'b0, 32'd0, 1'b0);
        // MUL with a three-cycle hold window.
        step(1'b0, 1'b1, 32'h0002_0190, 1'b0);
        repeat (2) step(1'b0, 1'b0, 32'd0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 32'd0, 1'b1);
        repeat (8) step(1'b0, 1'b0, 32'd0, 1'b0);
        // Reset in the middle of a long multiply, then an immediate restart.
        step(1'b0, 1'b1, 32'h00C4_3291, 1'b0);
        repeat (2) step(1'b0, 1'b0, 32'd0, 1'b0);
        step(1'b1, 1'b0, 32'd0, 1'b0);
        step(1'b0, 1'b1, 32'h00B8_7654, 1'b0);
        repeat (10) step(1'b0, 1'b0, 32'd0, 1'b0);
        // Random traffic.
        for (int n = 0; n < 1500; n++) begin
            step(($urandom % 64) == 0, ($urandom % 3) != 0, $urandom, ($urandom % 5) == 0);
        end
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
